pu_riscv_biu_arbiter: RTL and testbench
=======================================

// Module: pu_riscv_biu_arbiter
// PURPOSE
//  Two-master to one-slave BIU arbiter downstream of the PU instruction/data BIU ports.
//  Merges the ibiu_* and dbiu_* request streams onto a single biu_* port that feeds the bus bridge.
//  Round-robin grant with burst tracking; a grant is never switched mid-burst or while lock is held.
// PARAMETERS
//  XLEN  32  data width
//  PLEN  32  physical address width
// PORTS (x = i | d; master side faces the PU, slave side faces the bridge)
//  HCLK         in   1     clock, all state updates on rising edge
//  HRESET       in   1     asynchronous, active-high reset
//  xbiu_stb     in   1     master x request (address phase valid)
//  xbiu_stb_ack out  1     address phase accepted (slave stb_ack routed to owner)
//  xbiu_d_ack   out  1     write data accepted
//  xbiu_adri    in   PLEN  request address
//  xbiu_adro    out  PLEN  address of current data beat
//  xbiu_size    in   3     transfer size
//  xbiu_type    in   3     burst type: 0 SINGLE,1 INCR,2 WRAP4,3 INCR4,4 WRAP8,5 INCR8,6 WRAP16,7 INCR16
//  xbiu_we      in   1     write enable
//  xbiu_lock    in   1     keep grant across transactions
//  xbiu_prot    in   3     protection attributes
//  xbiu_d       in   XLEN  write data
//  xbiu_q       out  XLEN  read data
//  xbiu_ack     out  1     beat complete
//  xbiu_err     out  1     beat error
//  biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_we_o, biu_lock_o, biu_prot_o, biu_d_o
//               out  as master counterparts, slave request
//  biu_stb_ack_i, biu_d_ack_i, biu_adro_i, biu_q_i, biu_ack_i, biu_err_i
//               in   as master counterparts, slave response
// BEHAVIOUR
//  State: IDLE, GNT_I, GNT_D; last_gnt reg (reset = I); outstanding cnt[5:0]; accepted flag.
//  Reset: state = IDLE, cnt = 0, accepted = 0, last_gnt = I. All outputs decode from state, so every output is 0 in IDLE.
//  IDLE: one requester -> grant it. Both -> grant the one != last_gnt (first tie after reset goes to D).
//   Grant is registered: biu_stb_o rises 1 cycle after xbiu_stb first seen in IDLE.
//  Granted (owner o): slave request outputs = owner inputs, combinational.
//   Owner response outputs = slave inputs. Non-owner response outputs are all 0 (q/adro = 0).
//  biu_stb_o = o_stb & (!accepted | o_lock) & (cnt <= 16). Otherwise 0.
//  beats(type): SINGLE/INCR = 1, *4 = 4, *8 = 8, *16 = 16.
//  cnt update per cycle:
//   cnt += beats on (biu_stb_o & biu_stb_ack_i);
//   cnt -= 1 on biu_ack_i;
//   cnt  = 0 on biu_err_i (aborts rest of burst);
//   simultaneous accept + ack applies both.
//  accepted set on stb_ack; cleared on release or err.
//  Release when next_cnt == 0 & accepted & !o_lock. No release while cnt != 0, even if o_stb drops.
//   At release: last_gnt = o; arbitrate immediately using IDLE rules (direct handoff, no bubble).
//   If no requester, go to IDLE.
//  Locked owner keeps grant until a cycle with lock = 0 and cnt drained.
//  Owner stb low with cnt = 0 & !accepted (request withdrawn): return to IDLE.
//  Reset mid-burst: immediate IDLE, cnt cleared, in-flight beats discarded.
//  Slave responses with cnt = 0 are not routed and are ignored.
// TESTING
//  1 Reset, single I read (type 0): ibiu_stb at cycle 0 -> biu_stb_o at 1.
//    stb_ack at 1, ack + q = 0xDEADBEEF at 3 -> ibiu_ack/q at 3; IDLE at 4.
//  2 Both request at same cycle after reset -> D granted first.
//    After its SINGLE completes, I granted with no idle cycle; next tie grants D.
//  3 D INCR8 write, I requests during burst -> ibiu_stb_ack stays 0 until 8th biu_ack_i, then GNT_I next cycle.
//  4 D WRAP4 with biu_err_i on beat 2 -> dbiu_err = 1 that cycle, cnt = 0, grant moves to pending I next cycle.
//  5 D lock = 1 across two SINGLE transactions with I pending -> I blocked until D lock = 0 and 2nd ack.
//  6 HRESET during INCR16 beat 5 -> all outputs 0 at once.
//    Post-reset request is granted normally; stray biu_ack_i is not routed to either master.

Source files
------------

// File: rtl/pu_riscv_biu_arbiter.sv
// Merges the PU instruction and data BIU request streams onto one bridge-facing BIU port.
// Grants alternate round-robin, and a grant is held for a whole burst and while lock is asserted.
module pu_riscv_biu_arbiter #(
  parameter int XLEN = 32,
  parameter int PLEN = 32
) (
  input  logic            HCLK,
  input  logic            HRESET,

  input  logic            ibiu_stb,
  output logic            ibiu_stb_ack,
  output logic            ibiu_d_ack,
  input  logic [PLEN-1:0] ibiu_adri,
  output logic [PLEN-1:0] ibiu_adro,
  input  logic [2:0]      ibiu_size,
  input  logic [2:0]      ibiu_type,
  input  logic            ibiu_we,
  input  logic            ibiu_lock,
  input  logic [2:0]      ibiu_prot,
  input  logic [XLEN-1:0] ibiu_d,
  output logic [XLEN-1:0] ibiu_q,
  output logic            ibiu_ack,
  output logic            ibiu_err,

  input  logic            dbiu_stb,
  output logic            dbiu_stb_ack,
  output logic            dbiu_d_ack,
  input  logic [PLEN-1:0] dbiu_adri,
  output logic [PLEN-1:0] dbiu_adro,
  input  logic [2:0]      dbiu_size,
  input  logic [2:0]      dbiu_type,
  input  logic            dbiu_we,
  input  logic            dbiu_lock,
  input  logic [2:0]      dbiu_prot,
  input  logic [XLEN-1:0] dbiu_d,
  output logic [XLEN-1:0] dbiu_q,
  output logic            dbiu_ack,
  output logic            dbiu_err,

  output logic            biu_stb_o,
  output logic [PLEN-1:0] biu_adri_o,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic            biu_we_o,
  output logic            biu_lock_o,
  output logic [2:0]      biu_prot_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  input  logic [PLEN-1:0] biu_adro_i,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  state_t     state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       accepted, accepted_nxt;

  logic       own_i, own_d;
  logic       o_stb, o_lock;
  logic [2:0] o_type;
  logic       rsp_en, accept, ack_v, err_v;

  function automatic logic [5:0] burst_beats(input logic [2:0] btype);
    case (btype)
      3'd0, 3'd1: burst_beats = 6'd1;
      3'd2, 3'd3: burst_beats = 6'd4;
      3'd4, 3'd5: burst_beats = 6'd8;
      default:    burst_beats = 6'd16;
    endcase
  endfunction

  // On a tie the master that was not served last wins.
  function automatic state_t arbitrate(input logic req_i, input logic req_d, input logic last);
    if (req_i && req_d)
      arbitrate = (last == MST_D) ? GNT_I : GNT_D;
    else if (req_i)
      arbitrate = GNT_I;
    else if (req_d)
      arbitrate = GNT_D;
    else
      arbitrate = IDLE;
  endfunction

  assign own_i = (state == GNT_I);
  assign own_d = (state == GNT_D);

  always_comb begin : owner_mux
    o_stb      = 1'b0;
    o_lock     = 1'b0;
    o_type     = '0;
    biu_adri_o = '0;
    biu_size_o = '0;
    biu_we_o   = 1'b0;
    biu_prot_o = '0;
    biu_d_o    = '0;
    if (own_i) begin
      o_stb      = ibiu_stb;
      o_lock     = ibiu_lock;
      o_type     = ibiu_type;
      biu_adri_o = ibiu_adri;
      biu_size_o = ibiu_size;
      biu_we_o   = ibiu_we;
      biu_prot_o = ibiu_prot;
      biu_d_o    = ibiu_d;
    end else if (own_d) begin
      o_stb      = dbiu_stb;
      o_lock     = dbiu_lock;
      o_type     = dbiu_type;
      biu_adri_o = dbiu_adri;
      biu_size_o = dbiu_size;
      biu_we_o   = dbiu_we;
      biu_prot_o = dbiu_prot;
      biu_d_o    = dbiu_d;
    end
  end

  assign biu_type_o = o_type;
  assign biu_lock_o = o_lock;

  // A new address phase is offered only before the first accept, or back-to-back under lock.
  assign biu_stb_o = o_stb & (~accepted | o_lock) & (cnt <= 6'd16);

  // Data-phase responses only mean something while beats are outstanding.
  assign rsp_en = (cnt != 6'd0);
  assign accept = biu_stb_o & biu_stb_ack_i;
  assign ack_v  = biu_ack_i & rsp_en;
  assign err_v  = biu_err_i & rsp_en;

  assign ibiu_stb_ack = own_i & biu_stb_ack_i;
  assign ibiu_d_ack   = own_i & rsp_en & biu_d_ack_i;
  assign ibiu_adro    = (own_i & rsp_en) ? biu_adro_i : '0;
  assign ibiu_q       = (own_i & rsp_en) ? biu_q_i : '0;
  assign ibiu_ack     = own_i & ack_v;
  assign ibiu_err     = own_i & err_v;

  assign dbiu_stb_ack = own_d & biu_stb_ack_i;
  assign dbiu_d_ack   = own_d & rsp_en & biu_d_ack_i;
  assign dbiu_adro    = (own_d & rsp_en) ? biu_adro_i : '0;
  assign dbiu_q       = (own_d & rsp_en) ? biu_q_i : '0;
  assign dbiu_ack     = own_d & ack_v;
  assign dbiu_err     = own_d & err_v;

  always_comb begin : cnt_next
    cnt_nxt = cnt;
    if (accept)
      cnt_nxt = cnt_nxt + burst_beats(o_type);
    if (ack_v)
      cnt_nxt = cnt_nxt - 6'd1;
    if (err_v)
      cnt_nxt = '0;
  end

  always_comb begin : fsm_next
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    accepted_nxt = accepted;
    if (accept)
      accepted_nxt = 1'b1;
    if (err_v)
      accepted_nxt = 1'b0;
    case (state)
      IDLE: begin
        state_nxt    = arbitrate(ibiu_stb, dbiu_stb, last_gnt);
        accepted_nxt = 1'b0;
      end
      GNT_I, GNT_D: begin
        if ((cnt_nxt == 6'd0) && accepted && !o_lock) begin
          // Hand off in the same cycle the last beat completes, no idle bubble.
          last_gnt_nxt = own_d ? MST_D : MST_I;
          state_nxt    = arbitrate(ibiu_stb, dbiu_stb, last_gnt_nxt);
          accepted_nxt = 1'b0;
        end else if (!o_stb && (cnt == 6'd0) && !accepted) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= IDLE;
      last_gnt <= MST_I;
      cnt      <= '0;
      accepted <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      cnt      <= cnt_nxt;
      accepted <= accepted_nxt;
    end
  end

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Vector-table bench for pu_riscv_biu_arbiter: each row drives one cycle and queues the
// expected outputs, which are popped and compared mid-cycle.
module tb_pu_riscv_biu_arbiter;

  localparam int XLEN = 32;
  localparam int PLEN = 32;
  localparam logic [31:0] IADR = 32'h0000_1000;
  localparam logic [31:0] DADR = 32'h0000_2000;
  localparam logic [31:0] ADRO = 32'h0000_A0A0;
  localparam logic [31:0] IDAT = 32'h1111_0000;
  localparam logic [31:0] DDAT = 32'hD0D0_D0D0;
  localparam logic [2:0]  ISIZE = 3'd2;
  localparam logic [2:0]  DSIZE = 3'd1;
  localparam logic [2:0]  IPROT = 3'b100;
  localparam logic [2:0]  DPROT = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            ibiu_stb, ibiu_stb_ack, ibiu_d_ack, ibiu_we, ibiu_lock, ibiu_ack, ibiu_err;
  logic [PLEN-1:0] ibiu_adri, ibiu_adro;
  logic [2:0]      ibiu_size, ibiu_type, ibiu_prot;
  logic [XLEN-1:0] ibiu_d, ibiu_q;
  logic            dbiu_stb, dbiu_stb_ack, dbiu_d_ack, dbiu_we, dbiu_lock, dbiu_ack, dbiu_err;
  logic [PLEN-1:0] dbiu_adri, dbiu_adro;
  logic [2:0]      dbiu_size, dbiu_type, dbiu_prot;
  logic [XLEN-1:0] dbiu_d, dbiu_q;
  logic            biu_stb_o, biu_we_o, biu_lock_o;
  logic [PLEN-1:0] biu_adri_o, biu_adro_i;
  logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
  logic [XLEN-1:0] biu_d_o, biu_q_i;
  logic            biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i;

  pu_riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .HCLK(clk), .HRESET(rst),
    .ibiu_stb(ibiu_stb), .ibiu_stb_ack(ibiu_stb_ack), .ibiu_d_ack(ibiu_d_ack),
    .ibiu_adri(ibiu_adri), .ibiu_adro(ibiu_adro), .ibiu_size(ibiu_size), .ibiu_type(ibiu_type),
    .ibiu_we(ibiu_we), .ibiu_lock(ibiu_lock), .ibiu_prot(ibiu_prot), .ibiu_d(ibiu_d),
    .ibiu_q(ibiu_q), .ibiu_ack(ibiu_ack), .ibiu_err(ibiu_err),
    .dbiu_stb(dbiu_stb), .dbiu_stb_ack(dbiu_stb_ack), .dbiu_d_ack(dbiu_d_ack),
    .dbiu_adri(dbiu_adri), .dbiu_adro(dbiu_adro), .dbiu_size(dbiu_size), .dbiu_type(dbiu_type),
    .dbiu_we(dbiu_we), .dbiu_lock(dbiu_lock), .dbiu_prot(dbiu_prot), .dbiu_d(dbiu_d),
    .dbiu_q(dbiu_q), .dbiu_ack(dbiu_ack), .dbiu_err(dbiu_err),
    .biu_stb_o(biu_stb_o), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_we_o(biu_we_o), .biu_lock_o(biu_lock_o),
    .biu_prot_o(biu_prot_o), .biu_d_o(biu_d_o),
    .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i), .biu_adro_i(biu_adro_i),
    .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
  );

  typedef struct {
    logic        rst;
    logic        istb;
    logic [2:0]  itype;
    logic        ilock;
    logic        dstb;
    logic [2:0]  dtype;
    logic        dlock;
    logic        sack;
    logic        ack;
    logic        err;
    logic [31:0] q;
    logic        e_stb;
    int          e_own;
    logic        e_isack;
    logic        e_dsack;
    logic        e_iack;
    logic        e_dack;
    logic        e_ierr;
    logic        e_derr;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t v(input logic r, input logic istb, input logic [2:0] itype,
                             input logic ilock, input logic dstb, input logic [2:0] dtype,
                             input logic dlock, input logic sack, input logic ack, input logic err,
                             input logic [31:0] q, input logic e_stb, input int e_own,
                             input logic e_isack, input logic e_dsack, input logic e_iack,
                             input logic e_dack, input logic e_ierr, input logic e_derr);
    vec_t x;
    x.rst = r;  x.istb = istb; x.itype = itype; x.ilock = ilock;
    x.dstb = dstb; x.dtype = dtype; x.dlock = dlock;
    x.sack = sack; x.ack = ack; x.err = err; x.q = q;
    x.e_stb = e_stb; x.e_own = e_own; x.e_isack = e_isack; x.e_dsack = e_dsack;
    x.e_iack = e_iack; x.e_dack = e_dack; x.e_ierr = e_ierr; x.e_derr = e_derr;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic apply(input vec_t r);
    rst           = r.rst;
    ibiu_stb      = r.istb;  ibiu_type = r.itype; ibiu_lock = r.ilock;
    dbiu_stb      = r.dstb;  dbiu_type = r.dtype; dbiu_lock = r.dlock;
    biu_stb_ack_i = r.sack;
    biu_ack_i     = r.ack;
    biu_d_ack_i   = r.ack;
    biu_err_i     = r.err;
    biu_q_i       = r.q;
    biu_adro_i    = r.ack ? ADRO : 32'h0;
  endtask

  task automatic compare(input vec_t e, input int row);
    logic [31:0] e_adri, e_d;
    logic [10:0] e_attr;
    e_adri = (e.e_own == 1) ? IADR : (e.e_own == 2) ? DADR : 32'h0;
    e_d    = (e.e_own == 1) ? IDAT : (e.e_own == 2) ? DDAT : 32'h0;
    if (e.e_own == 1)      e_attr = {1'b0, e.ilock, ISIZE, e.itype, IPROT};
    else if (e.e_own == 2) e_attr = {1'b1, e.dlock, DSIZE, e.dtype, DPROT};
    else                   e_attr = '0;
    chk("biu_stb_o",    row, 32'(biu_stb_o), 32'(e.e_stb));
    chk("biu_adri_o",   row, biu_adri_o, e_adri);
    chk("biu_d_o",      row, biu_d_o, e_d);
    chk("biu_attr",     row, 32'({biu_we_o, biu_lock_o, biu_size_o, biu_type_o, biu_prot_o}), 32'(e_attr));
    chk("ibiu_stb_ack", row, 32'(ibiu_stb_ack), 32'(e.e_isack));
    chk("dbiu_stb_ack", row, 32'(dbiu_stb_ack), 32'(e.e_dsack));
    chk("ibiu_ack",     row, 32'(ibiu_ack), 32'(e.e_iack));
    chk("dbiu_ack",     row, 32'(dbiu_ack), 32'(e.e_dack));
    chk("ibiu_d_ack",   row, 32'(ibiu_d_ack), 32'(e.e_iack));
    chk("dbiu_d_ack",   row, 32'(dbiu_d_ack), 32'(e.e_dack));
    chk("ibiu_err",     row, 32'(ibiu_err), 32'(e.e_ierr));
    chk("dbiu_err",     row, 32'(dbiu_err), 32'(e.e_derr));
    chk("ibiu_q",       row, ibiu_q, e.e_iack ? e.q : 32'h0);
    chk("dbiu_q",       row, dbiu_q, e.e_dack ? e.q : 32'h0);
    chk("ibiu_adro",    row, ibiu_adro, e.e_iack ? ADRO : 32'h0);
    chk("dbiu_adro",    row, dbiu_adro, e.e_dack ? ADRO : 32'h0);
  endtask

  initial begin
    ibiu_adri = IADR; ibiu_size = ISIZE; ibiu_we = 1'b0; ibiu_prot = IPROT; ibiu_d = IDAT;
    dbiu_adri = DADR; dbiu_size = DSIZE; dbiu_we = 1'b1; dbiu_prot = DPROT; dbiu_d = DDAT;
    ibiu_stb = 0; ibiu_type = 0; ibiu_lock = 0;
    dbiu_stb = 0; dbiu_type = 0; dbiu_lock = 0;
    biu_stb_ack_i = 0; biu_ack_i = 0; biu_d_ack_i = 0; biu_err_i = 0;
    biu_q_i = '0; biu_adro_i = '0;

    // 1: reset state, then a single I read
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1, 1,0,0, 1,0,0, 1,1,1, 32'h1234,       0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 1,0,0, 32'h0,          1,1, 1,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,1, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,1,0, 32'hDEADBEEF,   0,1, 0,0,1,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));

    // 2: tie after reset goes to D, handoff to I without a bubble, next tie to D
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,0, 1,0,0, 32'h0,          1,2, 0,1,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 0,0,0, 32'h0,          0,2, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 0,1,0, 32'h1111_1111,  0,2, 0,0,0,1,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,0, 1,0,0, 32'h0,          1,1, 1,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,0,0, 0,0,0, 32'h0,          0,1, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,0, 0,1,0, 32'h2222_2222,  0,1, 0,0,1,0,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,0, 0,0,0, 32'h0,          1,2, 0,0,0,0,0,0));

    // 3: D INCR8 write holds the grant against a pending I until the eighth beat
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,5,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,5,0, 1,0,0, 32'h0,          1,2, 0,1,0,0,0,0));
    for (int b = 1; b <= 8; b++) begin
      if (b == 4)
        tbl.push_back(v(0, 1,0,0, 0,5,0, 0,0,0, 32'h0,      0,2, 0,0,0,0,0,0));
      tbl.push_back(v(0, 1,0,0, 0,5,0, 0,1,0, 32'hA0 + b,   0,2, 0,0,0,1,0,0));
    end
    tbl.push_back(v(0, 1,0,0, 0,0,0, 1,0,0, 32'h0,          1,1, 1,0,0,0,0,0));

    // 4: D WRAP4 aborted by an error on beat 2; I takes over with a clean count
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,2,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,2,0, 1,0,0, 32'h0,          1,2, 0,1,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,2,0, 0,1,0, 32'hB1,         0,2, 0,0,0,1,0,0));
    tbl.push_back(v(0, 1,0,0, 0,2,0, 0,0,1, 32'h0,          0,2, 0,0,0,0,0,1));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 1,0,0, 32'h0,          1,1, 1,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,1,0, 32'hB2,         0,1, 0,0,1,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));

    // 5: locked D across two singles keeps I out until lock drops and the second ack
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,0,1, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,1, 1,0,0, 32'h0,          1,2, 0,1,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,1, 0,1,0, 32'hC1,         1,2, 0,0,0,1,0,0));
    tbl.push_back(v(0, 1,0,0, 1,0,1, 1,0,0, 32'h0,          1,2, 0,1,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,1, 0,0,0, 32'h0,          0,2, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 0,1,0, 32'hC2,         0,2, 0,0,0,1,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 1,0,0, 32'h0,          1,1, 1,0,0,0,0,0));

    // 6: reset on beat 5 of an INCR16, stray acks afterwards are not routed
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,7,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 1,7,0, 1,0,0, 32'h0,          1,2, 0,1,0,0,0,0));
    for (int b = 1; b <= 4; b++)
      tbl.push_back(v(0, 0,0,0, 0,7,0, 0,1,0, 32'hE0 + b,   0,2, 0,0,0,1,0,0));
    tbl.push_back(v(1, 0,0,0, 0,7,0, 0,1,0, 32'hE5,         0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 0,1,0, 32'h5555,       0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 0,1,0, 32'h5555,       1,1, 0,0,0,0,0,0));
    tbl.push_back(v(0, 1,0,0, 0,0,0, 1,0,0, 32'h0,          1,1, 1,0,0,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,1,0, 32'h600D,       0,1, 0,0,1,0,0,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0, 0,0,0, 32'h0,          0,0, 0,0,0,0,0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk);
      #1;
      apply(tbl[k]);
      exp_q.push_back(tbl[k]);
      #3;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard row %0d: got empty queue expected one entry", k);
      end else begin
        compare(exp_q.pop_front(), k);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
